text_buffer_writer: RTL and testbench

Character-buffer writer that fills the text overlay's character store from a byte stream (UART, CPU, or test source). Accepts ASCII bytes on a valid/ready handshake, keeps a cursor, and interprets LF, CR and BS. Clears the buffer after reset and on request. Exposes a synchronous read port and a buffer-valid flag (`o_rd_dv`) that the text overlay uses as the write-complete side of its read-enable/data-valid handshake.

---
 rtl/text_overlay_pkg.sv | 25 ++
 rtl/char_buffer_ram.sv | 45 ++++
 rtl/text_buffer_writer.sv | 257 +++++++++++++++++++++++++
 tb/tb_text_buffer_writer.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_pkg.sv
// Shared definitions for the text overlay character-buffer writer.
//   tbw_state_t : writer FSM states (SCROLL exists only when
//                 TEXT_BUFFER_SCROLL_EN is defined)
//   ASCII_*     : character codes the writer interprets
// Optional feature macro: TEXT_BUFFER_SCROLL_EN
package text_overlay_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_IDLE      = 2'd1,
        ST_CLEAR_ROW = 2'd2
`ifdef TEXT_BUFFER_SCROLL_EN
        ,
        ST_SCROLL    = 2'd3
`endif
    } tbw_state_t;

    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

endpackage

// File: rtl/char_buffer_ram.sv
// Character store for the text overlay: one write port and two
// synchronous read ports, each with one cycle of latency.
//   clk, rst      : clock; rst clears only the overlay read register
//   we, wr_addr,
//   wr_data       : write port
//   rd_addr,
//   rd_data       : overlay read port (registered, reset to 0)
//   scroll_addr,
//   scroll_data   : scroll copy source read port (registered)
// A read of an address written on the same edge returns the old contents.
module char_buffer_ram #(
    parameter int DEPTH  = 20,
    parameter int CHAR_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] scroll_addr,
    output logic [CHAR_W-1:0] scroll_data
);

    logic [CHAR_W-1:0] mem [DEPTH];

    // The array itself is never reset; the writer's CLEAR pass initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        scroll_data <= mem[scroll_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_buffer_writer.sv
// Fills the text overlay character store from a byte stream.
// Accepts bytes on a valid/ready handshake, tracks a cursor and
// interprets LF, CR and BS. The whole buffer is cleared to spaces after
// reset and whenever i_clear is raised.
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_char, i_char_valid,
//   o_char_ready            : byte input handshake
//   i_clear                 : request a full buffer clear
//   i_rd_addr, o_rd_char    : overlay read port (row*COLUMNS + column)
//   o_rd_dv                 : buffer contents stable (writer idle)
//   o_cursor_x, o_cursor_y  : cursor position
// Optional feature macro: TEXT_BUFFER_SCROLL_EN -- on row overflow the
// text scrolls up one row instead of wrapping to the top row.
// Assumes ROWS >= 2 and COLUMNS >= 2.
module text_buffer_writer
    import text_overlay_pkg::*;
#(
    parameter int COLUMNS = 10,
    parameter int ROWS    = 2,
    parameter int CHAR_W  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [CHAR_W-1:0]               i_char,
    input  logic                            i_char_valid,
    output logic                            o_char_ready,
    input  logic                            i_clear,
    input  logic [$clog2(ROWS*COLUMNS)-1:0] i_rd_addr,
    output logic [CHAR_W-1:0]               o_rd_char,
    output logic                            o_rd_dv,
    output logic [$clog2(COLUMNS)-1:0]      o_cursor_x,
    output logic [$clog2(ROWS)-1:0]         o_cursor_y
);

    localparam int DEPTH  = ROWS * COLUMNS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int XW     = $clog2(COLUMNS);
    localparam int YW     = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(COLUMNS - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(COLUMNS - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(ROWS - 1);

    localparam logic [CHAR_W-1:0] C_SPACE     = CHAR_W'(ASCII_SPACE);
    localparam logic [CHAR_W-1:0] C_LF        = CHAR_W'(ASCII_LF);
    localparam logic [CHAR_W-1:0] C_CR        = CHAR_W'(ASCII_CR);
    localparam logic [CHAR_W-1:0] C_BS        = CHAR_W'(ASCII_BS);
    localparam logic [CHAR_W-1:0] C_PRINT_MIN = CHAR_W'(ASCII_PRINT_MIN);
    localparam logic [CHAR_W-1:0] C_PRINT_MAX = CHAR_W'(ASCII_PRINT_MAX);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [YW-1:0] y,
                                                    input logic [XW-1:0] x);
        return ADDR_W'(y) * ADDR_W'(COLUMNS) + ADDR_W'(x);
    endfunction

    tbw_state_t        state;
    logic [ADDR_W-1:0] cnt;        // shared by CLEAR, CLEAR_ROW and SCROLL
    logic [ADDR_W-1:0] row_base;   // first address of the row CLEAR_ROW wipes
    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;
    logic              rd_dv;

    logic              accept;
    logic              is_print;
    logic              is_lf;
    logic              is_cr;
    logic              is_bs;
    logic              line_end;
    logic              row_wrap;
    logic [ADDR_W-1:0] cur_addr;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CHAR_W-1:0] wdata;
    logic [ADDR_W-1:0] scroll_addr;
`ifdef TEXT_BUFFER_SCROLL_EN
    logic [CHAR_W-1:0] scroll_q;
`else
    logic [CHAR_W-1:0] unused_scroll_q;
`endif

    assign o_char_ready = (state == ST_IDLE) && !i_clear;
    assign accept       = i_char_valid && o_char_ready;

    assign is_print = (i_char >= C_PRINT_MIN) && (i_char <= C_PRINT_MAX);
    assign is_lf    = (i_char == C_LF);
    assign is_cr    = (i_char == C_CR);
    assign is_bs    = (i_char == C_BS);
    // A printable byte in the last column moves to the next line exactly like LF.
    assign line_end = is_lf || (is_print && (cur_x == X_LAST));
    assign row_wrap = line_end && (cur_y == Y_LAST);
    assign cur_addr = cell_addr(cur_y, cur_x);

    always_comb begin
        we    = 1'b0;
        waddr = cnt;
        wdata = C_SPACE;
        case (state)
            ST_CLEAR: begin
                we = 1'b1;
            end
            ST_CLEAR_ROW: begin
                we    = 1'b1;
                waddr = row_base + cnt;
            end
`ifdef TEXT_BUFFER_SCROLL_EN
            ST_SCROLL: begin
                we    = 1'b1;
                wdata = scroll_q;
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = i_char;
                    end else if (is_bs && (cur_x != '0)) begin
                        we    = 1'b1;
                        waddr = cur_addr - ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef TEXT_BUFFER_SCROLL_EN
    localparam logic [ADDR_W-1:0] SCROLL_LAST   = ADDR_W'((ROWS - 1) * COLUMNS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLUMNS);

    // The source is fetched one cycle ahead: while idle the port already
    // holds address COLUMNS, so copy step k writes mem[k] from the value
    // fetched during step k-1 and the copy runs at one word per cycle.
    always_comb begin
        if ((state == ST_SCROLL) && (cnt != SCROLL_LAST)) begin
            scroll_addr = cnt + ADDR_W'(COLUMNS + 1);
        end else begin
            scroll_addr = ADDR_W'(COLUMNS);
        end
    end
`else
    assign scroll_addr = '0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            row_base <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            rd_dv    <= 1'b0;
        end else begin
            rd_dv <= (state == ST_IDLE);
            case (state)
                ST_CLEAR: begin
                    if (i_clear) begin
                        cnt <= '0;
                    end else if (cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        cur_x <= '0;
                        cur_y <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else if (i_char_valid) begin
                        if (line_end) begin
                            cur_x <= '0;
                            if (row_wrap) begin
`ifdef TEXT_BUFFER_SCROLL_EN
                                state <= ST_SCROLL;
                                cnt   <= '0;
                                cur_y <= Y_LAST;
`else
                                state    <= ST_CLEAR_ROW;
                                row_base <= '0;
                                cnt      <= '0;
                                cur_y    <= '0;
`endif
                            end else begin
                                cur_y <= cur_y + YW'(1);
                            end
                        end else if (is_print) begin
                            cur_x <= cur_x + XW'(1);
                        end else if (is_cr) begin
                            cur_x <= '0;
                        end else if (is_bs && (cur_x != '0)) begin
                            cur_x <= cur_x - XW'(1);
                        end
                    end
                end
                ST_CLEAR_ROW: begin
                    if (i_clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else if (cnt == ROW_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
`ifdef TEXT_BUFFER_SCROLL_EN
                ST_SCROLL: begin
                    if (i_clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else if (cnt == SCROLL_LAST) begin
                        state    <= ST_CLEAR_ROW;
                        row_base <= LAST_ROW_BASE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    char_buffer_ram #(
        .DEPTH  (DEPTH),
        .CHAR_W (CHAR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk         (i_clk),
        .rst         (i_reset),
        .we          (we),
        .wr_addr     (waddr),
        .wr_data     (wdata),
        .rd_addr     (i_rd_addr),
        .rd_data     (o_rd_char),
        .scroll_addr (scroll_addr),
`ifdef TEXT_BUFFER_SCROLL_EN
        .scroll_data (scroll_q)
`else
        .scroll_data (unused_scroll_q)
`endif
    );

    assign o_rd_dv    = rd_dv;
    assign o_cursor_x = cur_x;
    assign o_cursor_y = cur_y;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Testbench for text_buffer_writer (default 10x2 buffer). A screen model
// (rows x columns array plus cursor) follows every accepted byte.
module tb_text_buffer_writer;

    localparam int COLS = 10;
    localparam int ROWS = 2;
    localparam int N    = ROWS * COLS;
    localparam int AW   = $clog2(N);
`ifdef TEXT_BUFFER_SCROLL_EN
    localparam int BUSY = ROWS * COLS;
`else
    localparam int BUSY = COLS;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [7:0]               ch;
    logic                     vld;
    logic                     clr;
    logic                     ready;
    logic [AW-1:0]            rd_addr;
    logic [7:0]               rd_char;
    logic                     rd_dv;
    logic [$clog2(COLS)-1:0]  cx;
    logic [$clog2(ROWS)-1:0]  cy;

    int compares = 0;
    int fails    = 0;

    logic [7:0] m_mem [ROWS][COLS];
    int         m_x;
    int         m_y;

    always #5 clk = ~clk;

    text_buffer_writer #(.COLUMNS(COLS), .ROWS(ROWS), .CHAR_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_char       (ch),
        .i_char_valid (vld),
        .o_char_ready (ready),
        .i_clear      (clr),
        .i_rd_addr    (rd_addr),
        .o_rd_char    (rd_char),
        .o_rd_dv      (rd_dv),
        .o_cursor_x   (cx),
        .o_cursor_y   (cy)
    );

    // ---------------- screen model ----------------
    function automatic void m_clear_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_mem[r][c] = 8'h20;
        m_x = 0;
        m_y = 0;
    endfunction

    function automatic void m_newline();
        m_x = 0;
        m_y = m_y + 1;
        if (m_y == ROWS) begin
`ifdef TEXT_BUFFER_SCROLL_EN
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    m_mem[r][c] = m_mem[r+1][c];
            for (int c = 0; c < COLS; c++) m_mem[ROWS-1][c] = 8'h20;
            m_y = ROWS - 1;
`else
            for (int c = 0; c < COLS; c++) m_mem[0][c] = 8'h20;
            m_y = 0;
`endif
        end
    endfunction

    function automatic void m_put(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_mem[m_y][m_x] = c;
            m_x = m_x + 1;
            if (m_x == COLS) m_newline();
        end else if (c == 8'h0A) begin
            m_newline();
        end else if (c == 8'h0D) begin
            m_x = 0;
        end else if (c == 8'h08) begin
            if (m_x > 0) begin
                m_x = m_x - 1;
                m_mem[m_y][m_x] = 8'h20;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    // Offers one byte, waits (bounded) for ready, returns #1 after the accepting edge.
    task automatic send(input logic [7:0] c, output int stall);
        stall = 0;
        @(negedge clk);
        ch  = c;
        vld = 1'b1;
        #1;
        while (ready !== 1'b1 && stall < 100) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (stall >= 100) begin
            compares++;
            fails++;
            $display("FAIL send_timeout char=%02h ready=%b required 1", c, ready);
            vld = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            vld = 1'b0;
            m_put(c);
        end
    endtask

    task automatic read_cell(input int a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = AW'(a);
        @(posedge clk);
        #1;
        d = rd_char;
    endtask

    task automatic clear_and_wait();
        int k;
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        m_clear_all();
        k = 0;
        while (ready !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            compares++;
            fails++;
            $display("FAIL clear_timeout ready=%b required 1", ready);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int low;
        logic [7:0] d;
        rst = 1'b1; vld = 1'b0; clr = 1'b0; ch = 8'h00; rd_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        compares++;
        if (ready !== 1'b0 || rd_dv !== 1'b0 || rd_char !== 8'h00 || cx !== '0 || cy !== '0) begin
            fails++;
            $display("FAIL reset_state ready=%b dv=%b char=%02h cur=(%0d,%0d) required 0,0,00,(0,0)",
                     ready, rd_dv, rd_char, cx, cy);
        end
        @(negedge clk);
        rst = 1'b0;
        m_clear_all();
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rd_dv === 1'b1) break;
            low++;
        end
        compares++;
        if (low != N) begin
            fails++;
            $display("FAIL reset_clear_len dv_low_cycles=%0d required %0d", low, N);
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL reset_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [5];
        logic [7:0] old0;
        logic [7:0] d;
        int st;
        int stalls;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        stalls = 0;
        @(negedge clk);
        rd_addr = '0;
        old0 = m_mem[0][0];
        send(msg[0], st);
        stalls += st;
        compares++;
        if (rd_char !== old0) begin
            fails++;
            $display("FAIL hello_rd_same_edge got %02h required %02h", rd_char, old0);
        end
        for (int i = 1; i < 5; i++) begin
            send(msg[i], st);
            stalls += st;
            if (i == 1) begin
                compares++;
                if (rd_char !== m_mem[0][0]) begin
                    fails++;
                    $display("FAIL hello_rd_next_edge got %02h required %02h", rd_char, m_mem[0][0]);
                end
            end
        end
        compares++;
        if (stalls != 0) begin
            fails++;
            $display("FAIL hello_ready stall_cycles=%0d required 0", stalls);
        end
        compares++;
        if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
            fails++;
            $display("FAIL hello_cursor got (%0d,%0d) required (%0d,%0d)", cx, cy, m_x, m_y);
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL hello_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_lf_and_ignored();
        logic [7:0] d;
        int st;
        send(8'h0A, st);
        send(8'h41, st);
        compares++;
        if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
            fails++;
            $display("FAIL lf_cursor got (%0d,%0d) required (%0d,%0d)", cx, cy, m_x, m_y);
        end
        read_cell(COLS, d);
        compares++;
        if (d !== m_mem[1][0]) begin
            fails++;
            $display("FAIL lf_mem10 got %02h required %02h", d, m_mem[1][0]);
        end
        send(8'h07, st);
        compares++;
        if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
            fails++;
            $display("FAIL bel_cursor got (%0d,%0d) required (%0d,%0d)", cx, cy, m_x, m_y);
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL bel_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_backspace();
        logic [7:0] d;
        int st;
        clear_and_wait();
        send(8'h61, st);
        send(8'h62, st);
        send(8'h63, st);
        send(8'h08, st);
        compares++;
        if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
            fails++;
            $display("FAIL bs_cursor got (%0d,%0d) required (%0d,%0d)", cx, cy, m_x, m_y);
        end
        read_cell(2, d);
        compares++;
        if (d !== m_mem[0][2]) begin
            fails++;
            $display("FAIL bs_mem2 got %02h required %02h", d, m_mem[0][2]);
        end
        send(8'h0D, st);
        send(8'h08, st);
        compares++;
        if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
            fails++;
            $display("FAIL bs_at_col0_cursor got (%0d,%0d) required (%0d,%0d)", cx, cy, m_x, m_y);
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL bs_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_row_overflow();
        logic [7:0] d;
        int st;
        int busy;
        clear_and_wait();
        for (int i = 0; i < N; i++) send(8'h61 + 8'(i), st);
        busy = 0;
        while (ready !== 1'b1 && busy < 100) begin
            busy++;
            @(posedge clk);
            #1;
        end
        compares++;
        if (busy != BUSY) begin
            fails++;
            $display("FAIL overflow_busy ready_low_cycles=%0d required %0d", busy, BUSY);
        end
        compares++;
        if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
            fails++;
            $display("FAIL overflow_cursor got (%0d,%0d) required (%0d,%0d)", cx, cy, m_x, m_y);
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL overflow_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_clear_collision();
        logic [7:0] d;
        int low;
        @(negedge clk);
        ch = 8'h5A; vld = 1'b1; clr = 1'b1;
        #1;
        compares++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL collide_ready got %b required 0", ready);
        end
        @(posedge clk);
        #1;
        vld = 1'b0; clr = 1'b0;
        m_clear_all();
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rd_dv === 1'b0) low++;
            else if (low > 0) break;
        end
        compares++;
        if (low != N) begin
            fails++;
            $display("FAIL collide_dv_low cycles=%0d required %0d", low, N);
        end
        compares++;
        if (cx !== '0 || cy !== '0) begin
            fails++;
            $display("FAIL collide_cursor got (%0d,%0d) required (0,0)", cx, cy);
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL collide_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_clear_restart();
        logic [7:0] d;
        int st;
        int busy;
        // clear while the overflow row operation is in progress
        for (int i = 0; i < N; i++) send(8'h41 + 8'(i), st);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        busy = 0;
        while (ready !== 1'b1 && busy < 100) begin
            busy++;
            @(posedge clk);
            #1;
        end
        compares++;
        if (busy != N) begin
            fails++;
            $display("FAIL restart_from_row_op busy=%0d required %0d", busy, N);
        end
        // clear again part-way through a running CLEAR
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        busy = 0;
        while (ready !== 1'b1 && busy < 100) begin
            busy++;
            @(posedge clk);
            #1;
        end
        compares++;
        if (busy != N) begin
            fails++;
            $display("FAIL restart_mid_clear busy=%0d required %0d", busy, N);
        end
        // reset part-way through a CLEAR
        send(8'h51, st);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compares++;
        if (ready !== 1'b0 || rd_dv !== 1'b0 || cx !== '0 || cy !== '0) begin
            fails++;
            $display("FAIL midreset_state ready=%b dv=%b cur=(%0d,%0d) required 0,0,(0,0)", ready, rd_dv, cx, cy);
        end
        @(negedge clk);
        rst = 1'b0;
        busy = 0;
        while (ready !== 1'b1 && busy < 100) begin
            busy++;
            @(posedge clk);
            #1;
        end
        compares++;
        if (busy != N) begin
            fails++;
            $display("FAIL midreset_clear_len busy=%0d required %0d", busy, N);
        end
        m_clear_all();
        @(posedge clk);
        #1;
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL restart_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        logic [7:0] d;
        int st;
        int kind;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)       c = 8'($urandom_range(32, 126));
            else if (kind == 6)  c = 8'h0A;
            else if (kind == 7)  c = 8'h0D;
            else if (kind == 8)  c = 8'h08;
            else                 c = ($urandom_range(0, 1) == 0) ? 8'h07 : (8'h80 | 8'($urandom_range(0, 127)));
            send(c, st);
            compares++;
            if (cx !== m_x[$bits(cx)-1:0] || cy !== m_y[$bits(cy)-1:0]) begin
                fails++;
                $display("FAIL rand_cursor byte#%0d=%02h got (%0d,%0d) required (%0d,%0d)", i, c, cx, cy, m_x, m_y);
            end
        end
        // let any trailing row operation finish
        st = 0;
        while (ready !== 1'b1 && st < 100) begin
            st++;
            @(posedge clk);
            #1;
        end
        for (int a = 0; a < N; a++) begin
            read_cell(a, d);
            compares++;
            if (d !== m_mem[a/COLS][a%COLS]) begin
                fails++;
                $display("FAIL rand_mem[%0d] got %02h required %02h", a, d, m_mem[a/COLS][a%COLS]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_lf_and_ignored();
        test_backspace();
        test_row_overflow();
        test_clear_collision();
        test_clear_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
